video_timing_pipe: RTL and testbench

- Pixel-stream transmitter for the 640x480@60 HDMI text path.
- Generates the raster counters (draw_x/draw_y) that drive the glyph/palette lookup pipeline.
- Accepts that pipeline's RGB after a fixed latency and emits the aligned hsync/vsync/vde/RGB stream consumed by the HDMI encoder and by the bench frame capture.
- Sits between the pixel clock source and the TMDS encoder inside hdmi_text_controller.

---
 rtl/video_timing_pkg.sv | 35 +++
 rtl/video_timing_pipe_if.sv | 34 +++
 rtl/video_delay_line.sv | 27 ++
 rtl/video_timing_pipe.sv | 126 ++++++++++++
 tb/tb_video_timing_pipe.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared timing defaults and pixel/sideband types for the 640x480 text path
// Contents: DEF_* 640x480@60 timing defaults, derived DEF_H_TOTAL/DEF_V_TOTAL,
//           coord_t raster coordinate, rgb444_t pixel, sideband_t sync/enable/coordinate bundle.
package video_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // hs/vs are logical "inside the sync pulse" flags, not pin levels: a cleared
  // entry therefore means "no sync", independent of the output polarity.
  typedef struct packed {
    logic   hs;
    logic   vs;
    logic   de;
    coord_t x;
    coord_t y;
  } sideband_t;

endpackage

// File: rtl/video_timing_pipe_if.sv
// rtl/video_timing_pipe_if.sv - raster/pixel bus between the timing pipe and its pixel client/encoder
// master: timing pipe (drives draw_* decodes and the aligned output stream, reads rgb_in)
// slave : pixel client / encoder side (reads draw_* and outputs, drives rgb_in)
interface video_timing_pipe_if;
  import video_timing_pkg::*;

  coord_t     draw_x;
  coord_t     draw_y;
  logic       draw_active;
  logic       line_start;
  logic       frame_start;
  rgb444_t    rgb_in;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       hsync;
  logic       vsync;
  logic       vde;
  coord_t     out_x;
  coord_t     out_y;

  modport master (
    output draw_x, draw_y, draw_active, line_start, frame_start,
    input  rgb_in,
    output red, green, blue, hsync, vsync, vde, out_x, out_y
  );

  modport slave (
    input  draw_x, draw_y, draw_active, line_start, frame_start,
    output rgb_in,
    input  red, green, blue, hsync, vsync, vde, out_x, out_y
  );

endinterface

// File: rtl/video_delay_line.sv
// rtl/video_delay_line.sv - DEPTH-stage register delay line with synchronous clear
// Ports: pixel_clk clock; arstn sync active-low clear of every stage;
//        d input word; q word presented DEPTH cycles earlier (0 after clear).
module video_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             pixel_clk,
  input  logic             arstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_pipe.sv
// rtl/video_timing_pipe.sv - raster counters plus latency-matched hsync/vsync/vde/RGB output stage
// Ports: pixel_clk pixel clock; arstn sync active-low reset;
//        vif (master) draw_x/draw_y/draw_active/line_start/frame_start raster decodes,
//        rgb_in client colour PIPE_LAT cycles after its coordinate, and the registered
//        red/green/blue/hsync/vsync/vde/out_x/out_y stream aligned PIPE_LAT+1 after the counter;
//        frame_cnt completed-frame counter.
module video_timing_pipe
  import video_timing_pkg::*;
#(
  parameter int PIPE_LAT = 2,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                pixel_clk,
  input  logic                arstn,
  video_timing_pipe_if.master vif,
  output logic [15:0]         frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_bad_pipe_lat
    $error("video_timing_pipe: PIPE_LAT must be within 1..8");
  end
  if (H_TOTAL >= 1024 || V_TOTAL >= 1024) begin : g_bad_total
    $error("video_timing_pipe: H_TOTAL and V_TOTAL must be below 1024");
  end

  localparam coord_t H_LAST  = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST  = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT   = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT   = coord_t'(V_ACTIVE);
  localparam coord_t HS_BEG  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_END  = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t VS_BEG  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_END  = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t    h_cnt;
  coord_t    v_cnt;
  logic      h_wrap;
  logic      v_wrap;
  sideband_t sb_raw;
  sideband_t sb_tap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      frame_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      if (v_wrap) begin
        v_cnt     <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Raster decodes are combinational so the client sees them in the same
  // cycle as the counter value; while reset is held they read as (0,0).
  assign vif.draw_x      = h_cnt;
  assign vif.draw_y      = v_cnt;
  assign vif.draw_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign vif.line_start  = (h_cnt == '0) && (v_cnt < V_ACT);
  assign vif.frame_start = (h_cnt == '0) && (v_cnt == '0);

  always_comb begin
    sb_raw    = '0;
    sb_raw.hs = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    sb_raw.vs = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    sb_raw.de = vif.draw_active;
    sb_raw.x  = h_cnt;
    sb_raw.y  = v_cnt;
  end

  // PIPE_LAT stages: the tap holds the sideband of the coordinate whose
  // colour the client is driving on rgb_in in the same cycle.
  video_delay_line #(
    .WIDTH ($bits(sideband_t)),
    .DEPTH (PIPE_LAT)
  ) u_sb_delay (
    .pixel_clk (pixel_clk),
    .arstn     (arstn),
    .d         (sb_raw),
    .q         (sb_tap)
  );

  always_ff @(posedge pixel_clk) begin
    if (!arstn) begin
      vif.red   <= '0;
      vif.green <= '0;
      vif.blue  <= '0;
      vif.hsync <= ~SYNC_POL;
      vif.vsync <= ~SYNC_POL;
      vif.vde   <= 1'b0;
      vif.out_x <= '0;
      vif.out_y <= '0;
    end else begin
      // Blanking forces black so whatever the client drives there is ignored.
      vif.red   <= sb_tap.de ? vif.rgb_in.r : 4'h0;
      vif.green <= sb_tap.de ? vif.rgb_in.g : 4'h0;
      vif.blue  <= sb_tap.de ? vif.rgb_in.b : 4'h0;
      vif.hsync <= sb_tap.hs ? SYNC_POL : ~SYNC_POL;
      vif.vsync <= sb_tap.vs ? SYNC_POL : ~SYNC_POL;
      vif.vde   <= sb_tap.de;
      vif.out_x <= sb_tap.x;
      vif.out_y <= sb_tap.y;
    end
  end

endmodule

// File: tb/tb_video_timing_pipe.sv
// tb/tb_video_timing_pipe.sv - self-checking bench for video_timing_pipe (reduced and default geometry)
module tb_video_timing_pipe;
  import video_timing_pkg::*;

  localparam int PL    = 2;
  localparam int S_HA  = 40, S_HFP = 4, S_HS = 6, S_HBP = 6;
  localparam int S_VA  = 30, S_VFP = 3, S_VS = 2, S_VBP = 4;
  localparam int S_HT  = S_HA + S_HFP + S_HS + S_HBP;
  localparam int S_VT  = S_VA + S_VFP + S_VS + S_VBP;
  localparam int S_FR  = S_HT * S_VT;

  logic pixel_clk = 1'b0;
  logic arstn     = 1'b0;
  always #20 pixel_clk = ~pixel_clk;

  video_timing_pipe_if vif_s ();
  video_timing_pipe_if vif_d ();
  logic [15:0] frame_cnt_s;
  logic [15:0] frame_cnt_d;

  video_timing_pipe #(
    .PIPE_LAT (PL),
    .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
    .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP),
    .SYNC_POL (1'b0)
  ) u_small (
    .pixel_clk (pixel_clk),
    .arstn     (arstn),
    .vif       (vif_s),
    .frame_cnt (frame_cnt_s)
  );

  video_timing_pipe u_dflt (
    .pixel_clk (pixel_clk),
    .arstn     (arstn),
    .vif       (vif_d),
    .frame_cnt (frame_cnt_d)
  );

  int          compared   = 0;
  int          mismatched = 0;
  int          n          = 0;   // edges since the last edge that saw arstn=0
  int          mode       = 0;   // 0 coordinate pattern, 1 all-ones, 2 random
  logic [11:0] rgb_prev   = 12'h000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int hpos(input int k);
    return k % S_HT;
  endfunction

  function automatic int vpos(input int k);
    return (k / S_HT) % S_VT;
  endfunction

  function automatic logic [11:0] pattern(input int k);
    if (k < 0) return 12'h000;
    return 12'(((hpos(k) % 16) << 8) | ((vpos(k) % 16) << 4) | 10);
  endfunction

  // Reference: counter at cycle n is raster position n; the output at cycle n
  // shows raster position n-PL-1 (or reset values before that exists) with the
  // colour the client drove in cycle n-1.
  task automatic check_small();
    int h, v, p, ph, pv;
    bit de, hs_on, vs_on;
    h = hpos(n);
    v = vpos(n);
    check("draw_x", 32'(vif_s.draw_x), h);
    check("draw_y", 32'(vif_s.draw_y), v);
    check("draw_active", 32'(vif_s.draw_active), 32'(h < S_HA && v < S_VA));
    check("line_start", 32'(vif_s.line_start), 32'(h == 0 && v < S_VA));
    check("frame_start", 32'(vif_s.frame_start), 32'(h == 0 && v == 0));
    check("frame_cnt", 32'(frame_cnt_s), (n / S_FR) % 65536);
    de = 0; hs_on = 0; vs_on = 0; ph = 0; pv = 0;
    if (n >= PL + 1) begin
      p     = n - PL - 1;
      ph    = hpos(p);
      pv    = vpos(p);
      de    = (ph < S_HA) && (pv < S_VA);
      hs_on = (ph >= S_HA + S_HFP) && (ph < S_HA + S_HFP + S_HS);
      vs_on = (pv >= S_VA + S_VFP) && (pv < S_VA + S_VFP + S_VS);
    end
    check("vde", 32'(vif_s.vde), 32'(de));
    check("hsync", 32'(vif_s.hsync), 32'(!hs_on));
    check("vsync", 32'(vif_s.vsync), 32'(!vs_on));
    check("out_x", 32'(vif_s.out_x), ph);
    check("out_y", 32'(vif_s.out_y), pv);
    check("rgb", 32'({vif_s.red, vif_s.green, vif_s.blue}), 32'(de ? rgb_prev : 12'h000));
  endtask

  task automatic tick();
    logic [11:0] nxt;
    @(posedge pixel_clk);
    if (!arstn) n = 0;
    else        n = n + 1;
    #1;
    check_small();
    case (mode)
      0:       nxt = pattern(n - PL);
      1:       nxt = 12'hFFF;
      default: nxt = 12'($urandom);
    endcase
    vif_s.rgb_in = nxt;
    rgb_prev     = nxt;
  endtask

  initial begin
    int hs_fall, hs_w, ls_at, fs_at, vde_cnt, vs_low, vs_first;
    bit done;
    vif_s.rgb_in = 12'h000;
    vif_d.rgb_in = 12'hFFF;
    arstn        = 1'b0;
    repeat (4) tick();

    check("rst_rgb_d", 32'({vif_d.red, vif_d.green, vif_d.blue}), 0);
    check("rst_vde_d", 32'(vif_d.vde), 0);
    check("rst_hsync_d", 32'(vif_d.hsync), 1);
    check("rst_vsync_d", 32'(vif_d.vsync), 1);
    check("rst_frame_cnt_d", 32'(frame_cnt_d), 0);
    check("rst_draw_xy_d", 32'({vif_d.draw_x, vif_d.draw_y}), 0);
    check("rst_frame_start_d", 32'(vif_d.frame_start), 1);

    arstn = 1'b1;
    tick();
    check("first_edge_x_d", 32'(vif_d.draw_x), 1);

    // Default 640x480 geometry: line-level timing.
    hs_fall = -1;
    for (int i = 0; i < 2000 && hs_fall < 0; i++) begin
      tick();
      if (vif_d.hsync == 1'b0) hs_fall = n;
    end
    check("hsync_fall_cycle_d", hs_fall, 656 + PL + 1);
    hs_w = 1;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (vif_d.hsync == 1'b0) hs_w++;
      else                     done = 1;
    end
    check("hsync_width_d", hs_w, 96);
    ls_at = -1;
    for (int i = 0; i < 2000 && ls_at < 0; i++) begin
      tick();
      if (vif_d.line_start) ls_at = n;
    end
    check("line_start_period_d", ls_at, 800);

    // Reduced geometry: frame-level timing with the coordinate pattern.
    fs_at = -1;
    for (int i = 0; i < 3 * S_FR && fs_at < 0; i++) begin
      tick();
      if (vif_s.frame_start) fs_at = n;
    end
    check("frame_start_period_s", fs_at, S_FR);
    check("frame_cnt_first_wrap_s", 32'(frame_cnt_s), 1);

    // Second frame with all-ones client colour: blanking must stay black.
    mode     = 1;
    vde_cnt  = 0;
    vs_low   = 0;
    vs_first = -1;
    for (int i = 0; i < S_FR; i++) begin
      if (vif_s.vde) vde_cnt++;
      if (vif_s.vsync == 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = n;
      end
      tick();
    end
    check("vde_per_frame_s", vde_cnt, S_HA * S_VA);
    check("vsync_low_cycles_s", vs_low, S_VS * S_HT);
    check("vsync_first_low_s", vs_first, S_FR + (S_VA + S_VFP) * S_HT + PL + 1);
    check("frame_start_second_s", 32'(vif_s.frame_start), 1);
    check("frame_cnt_second_s", 32'(frame_cnt_s), 2);

    // Random colour, then a one-cycle reset in the middle of the frame.
    mode = 2;
    done = 0;
    for (int i = 0; i < 3 * S_FR && !done; i++) begin
      tick();
      if (vif_s.draw_y == 10'd20 && vif_s.draw_x == 10'd30) done = 1;
    end
    check("reached_mid_frame_s", 32'(done), 1);
    arstn = 1'b0;
    tick();
    check("midrst_vde", 32'(vif_s.vde), 0);
    check("midrst_sync", 32'({vif_s.hsync, vif_s.vsync}), 3);
    check("midrst_rgb", 32'({vif_s.red, vif_s.green, vif_s.blue}), 0);
    check("midrst_frame_cnt", 32'(frame_cnt_s), 0);
    check("midrst_out_xy", 32'({vif_s.out_x, vif_s.out_y}), 0);
    arstn = 1'b1;
    for (int i = 0; i < PL + 1; i++) begin
      tick();
      check("post_rst_no_sync", 32'({vif_s.hsync, vif_s.vsync}), 3);
    end
    fs_at = -1;
    for (int i = 0; i < 3 * S_FR && fs_at < 0; i++) begin
      tick();
      if (vif_s.frame_start) fs_at = n;
    end
    check("frame_start_after_rst_s", fs_at, S_FR);
    repeat (200) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
